// File: rtl/halflife_pkg.sv
// Shared types and defaults for the half-life decay timer.
// Optional generation counter enabled by defining HALFLIFE_GEN_CNT_EN.
package halflife_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } hl_state_t;

    localparam int unsigned HL_WIDTH_DEF    = 8;
    localparam int unsigned HL_PERIOD_W_DEF = 16;
    localparam int unsigned GEN_CNT_W       = 8;

endpackage

// File: rtl/halflife_decay_timer_if.sv
// Control/status bundle between the half-life timer and its user.
// Carries gen_cnt only when HALFLIFE_GEN_CNT_EN is defined.
interface halflife_decay_timer_if
    import halflife_pkg::*;
#(
    parameter int unsigned WIDTH    = HL_WIDTH_DEF,
    parameter int unsigned PERIOD_W = HL_PERIOD_W_DEF
);
    logic                load;
    logic [WIDTH-1:0]    in_val;
    logic [PERIOD_W-1:0] period;
    logic [WIDTH-1:0]    floor;
    logic                start;
    logic                pause;
    logic                up;
    logic                down;
    logic [WIDTH-1:0]    out;
    logic                busy;
    logic                done;
    logic                tick;
`ifdef HALFLIFE_GEN_CNT_EN
    logic [GEN_CNT_W-1:0] gen_cnt;
`endif

    modport master (
        output load, in_val, period, floor, start, pause, up, down,
        input  out, busy, done, tick
`ifdef HALFLIFE_GEN_CNT_EN
        , input gen_cnt
`endif
    );

    modport slave (
        input  load, in_val, period, floor, start, pause, up, down,
        output out, busy, done, tick
`ifdef HALFLIFE_GEN_CNT_EN
        , output gen_cnt
`endif
    );

endinterface

// File: rtl/halflife_prescaler.sv
// Reloadable down-counter pacing the halvings; zero marks a halving edge.
module halflife_prescaler #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                reload,
    input  logic [PERIOD_W-1:0] reload_val,
    input  logic                en,
    output logic                zero
);
    logic [PERIOD_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (reload) begin
            cnt_q <= reload_val;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/halflife_decay_timer.sv
// Half-life timer: quantity halves every `period` cycles until it reaches floor.
// Define HALFLIFE_GEN_CNT_EN to add the gen_cnt halving counter.
module halflife_decay_timer
    import halflife_pkg::*;
#(
    parameter int unsigned WIDTH    = HL_WIDTH_DEF,
    parameter int unsigned PERIOD_W = HL_PERIOD_W_DEF
) (
    input logic                   clk,
    input logic                   rst,
    halflife_decay_timer_if.slave bus
);
    hl_state_t           state_q, state_d;
    logic [WIDTH-1:0]    out_q, out_d, half, stepped;
    logic                tick_q, tick_d;
    logic [PERIOD_W-1:0] per_q, per_d, per_eff;
    logic                pre_clr, pre_reload, pre_en, pre_zero;
    logic [PERIOD_W-1:0] pre_reload_val;
    logic                start_eff;

    assign per_eff = (bus.period == '0) ? PERIOD_W'(1) : bus.period;
    assign half    = out_q >> 1;

    // Saturating manual step; up and down together cancel.
    always_comb begin
        stepped = out_q;
        if (bus.up && !bus.down && out_q != '1) begin
            stepped = out_q + 1'b1;
        end else if (bus.down && !bus.up && out_q != '0) begin
            stepped = out_q - 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        out_d          = out_q;
        tick_d         = 1'b0;
        per_d          = per_q;
        pre_clr        = 1'b0;
        pre_reload     = 1'b0;
        pre_reload_val = per_q - 1'b1;
        pre_en         = 1'b0;
        start_eff      = 1'b0;
        if (bus.load) begin
            out_d   = bus.in_val;
            state_d = IDLE;
            pre_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        start_eff = 1'b1;
                        if (out_q > bus.floor) begin
                            state_d        = RUN;
                            per_d          = per_eff;
                            pre_reload     = 1'b1;
                            pre_reload_val = per_eff - 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        out_d = stepped;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (pre_zero) begin
                        out_d      = half;
                        tick_d     = 1'b1;
                        pre_reload = 1'b1;
                        if (half <= bus.floor) begin
                            state_d = DONE;
                        end
                    end else begin
                        pre_en = 1'b1;
                    end
                end
                PAUSED: begin
                    out_d = stepped;
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            tick_q  <= 1'b0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
            per_q   <= per_d;
        end
    end

    halflife_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .clr        (pre_clr),
        .reload     (pre_reload),
        .reload_val (pre_reload_val),
        .en         (pre_en),
        .zero       (pre_zero)
    );

`ifdef HALFLIFE_GEN_CNT_EN
    logic [GEN_CNT_W-1:0] gen_q;

    always_ff @(posedge clk) begin
        if (rst || bus.load || start_eff) begin
            gen_q <= '0;
        end else if (tick_d && gen_q != '1) begin
            gen_q <= gen_q + 1'b1;
        end
    end

    assign bus.gen_cnt = gen_q;
`else
    // start_eff only feeds the generation counter.
    logic unused_start_eff;
    assign unused_start_eff = start_eff;
`endif

    assign bus.out  = out_q;
    assign bus.busy = (state_q == RUN) || (state_q == PAUSED);
    assign bus.done = (state_q == DONE);
    assign bus.tick = tick_q;

endmodule
